// File: rtl/mkio_rx_pkg.sv
// Shared types and constants for the MKIO receive buffer controller.
package mkio_rx_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_FULL = 2'd2,
        S_ERR  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_SHORT   = 2'b10,
        ERR_OVERRUN = 2'b11
    } rx_err_t;

    localparam int CMD_CNT_W        = 5;
    // A zero word-count field in the command word means a full 32-word message.
    localparam int COUNT_ZERO_WORDS = 32;
endpackage

// File: rtl/mkio_word_timer.sv
// Inter-word gap timer; saturates at TIMEOUT, which is reported as expiry.
module mkio_word_timer #(
    parameter int TIMEOUT = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

    assign expired = (count == TW'(TIMEOUT));
endmodule

// File: rtl/mkio_rx_buf_ctrl.sv
// Receive buffer controller: stores message data words into an external RAM
// and serves host reads of that RAM while no message is in progress.
module mkio_rx_buf_ctrl
    import mkio_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [DATA_WIDTH-1:0] cmd_word,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_word,
    input  logic                  msg_end,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  host_rd_valid,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  msg_done,
    output logic                  msg_error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   word_cnt
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    rx_state_t             state, state_nx;
    rx_err_t               err_q, err_nx;
    logic [CNT_W-1:0]      exp_cnt, cnt_inc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  do_write, done_set, err_set, tmr_expired;
    logic                  unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_word[DATA_WIDTH-1:CMD_CNT_W];

    mkio_word_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (cmd_valid | data_valid),
        .enable  ((state == S_RECV) || (state == S_FULL)),
        .expired (tmr_expired)
    );

    assign cnt_inc = word_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        err_nx   = ERR_NONE;
        do_write = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        if (cmd_valid) begin
            state_nx = S_RECV;
        end else begin
            case (state)
                S_RECV: begin
                    // A data word in the same cycle as msg_end is counted before msg_end is judged.
                    if (data_valid) begin
                        do_write = 1'b1;
                        if (cnt_inc == exp_cnt) begin
                            if (msg_end) begin
                                done_set = 1'b1;
                                state_nx = S_IDLE;
                            end else begin
                                state_nx = S_FULL;
                            end
                        end else if (msg_end) begin
                            err_set  = 1'b1;
                            err_nx   = ERR_SHORT;
                            state_nx = S_ERR;
                        end
                    end else if (msg_end) begin
                        err_set  = 1'b1;
                        err_nx   = ERR_SHORT;
                        state_nx = S_ERR;
                    end else if (tmr_expired) begin
                        err_set  = 1'b1;
                        err_nx   = ERR_TIMEOUT;
                        state_nx = S_ERR;
                    end
                end
                S_FULL: begin
                    if (data_valid) begin
                        err_set  = 1'b1;
                        err_nx   = ERR_OVERRUN;
                        state_nx = S_ERR;
                    end else if (msg_end || tmr_expired) begin
                        done_set = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            err_q          <= ERR_NONE;
            exp_cnt        <= '0;
            word_cnt       <= '0;
            wr_ptr         <= '0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
            mem_data       <= '0;
            msg_done       <= 1'b0;
            host_rd_valid  <= 1'b0;
        end else begin
            state         <= state_nx;
            mem_we        <= do_write;
            msg_done      <= done_set;
            host_rd_valid <= host_rd_req && (state == S_IDLE);
            if (do_write) begin
                mem_write_addr <= wr_ptr;
                mem_data       <= data_word;
                word_cnt       <= cnt_inc;
                // The last slot is never followed by another write in the same message.
                if (wr_ptr != '1)
                    wr_ptr <= wr_ptr + 1'b1;
            end
            if (cmd_valid) begin
                exp_cnt  <= (cmd_word[CMD_CNT_W-1:0] == '0) ? CNT_W'(COUNT_ZERO_WORDS)
                                                            : CNT_W'(cmd_word[CMD_CNT_W-1:0]);
                word_cnt <= '0;
                wr_ptr   <= '0;
                err_q    <= ERR_NONE;
            end else if (err_set) begin
                err_q <= err_nx;
            end
        end
    end

    assign busy          = (state != S_IDLE);
    assign msg_error     = (state == S_ERR);
    assign err_code      = err_q;
    assign mem_read_addr = host_rd_addr;
    assign host_rd_data  = host_rd_valid ? mem_q : '0;
endmodule

// File: tb/tb_mkio_rx_buf_ctrl.sv
// Self-checking bench for mkio_rx_buf_ctrl with a message-level reference model.
module tb_mkio_rx_buf_ctrl;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, data_valid, msg_end, host_rd_req;
    logic [DW-1:0] cmd_word, data_word;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_rd_data, mem_data, mem_q;
    logic          host_rd_valid, mem_we, busy, msg_done, msg_error;
    logic [AW-1:0] mem_write_addr, mem_read_addr;
    logic [1:0]    err_code;
    logic [AW:0]   word_cnt;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;

    logic [DW-1:0] ram [32];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] wq[$];

    always #5 clock = ~clock;

    mkio_rx_buf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .data_valid(data_valid), .data_word(data_word), .msg_end(msg_end),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_we(mem_we),
        .mem_read_addr(mem_read_addr), .mem_q(mem_q), .busy(busy),
        .msg_done(msg_done), .msg_error(msg_error), .err_code(err_code),
        .word_cnt(word_cnt)
    );

    // External RAM with registered read, plus a log of every write issued.
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_write_addr] <= mem_data;
            wa_q.push_back(mem_write_addr);
            wd_q.push_back(mem_data);
        end
        mem_q <= ram[mem_read_addr];
        if (msg_done)  n_done++;
        if (msg_error) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
    endtask

    task automatic send_cmd(input int n);
        logic [DW-1:0] w;
        w = DW'($urandom);
        w[4:0] = 5'(n);
        cmd_valid = 1'b1;
        cmd_word  = w;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic me);
        data_valid = 1'b1;
        data_word  = w;
        msg_end    = me;
        cycle();
        data_valid = 1'b0;
        msg_end    = 1'b0;
    endtask

    // term: 0 = msg_end after the last word, 1 = go silent, 2 = msg_end with the last word.
    task automatic run_msg(input string tag, input int n, input int term, input bit rd_busy);
        int d0, e0, k, wn, gap;
        logic [1:0] exp_err;
        d0 = n_done;
        e0 = n_err;
        k  = wq.size();
        wa_q.delete();
        wd_q.delete();
        send_cmd(n);
        check({tag, ".busy"}, busy, 1);
        if (rd_busy) begin
            host_rd_req  = 1'b1;
            host_rd_addr = '0;
            cycle();
            host_rd_req = 1'b0;
            check({tag, ".rd_ignored"}, host_rd_valid, 0);
        end
        for (int i = 0; i < k; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) cycle();
            send_word(wq[i], (term == 2) && (i == k - 1));
        end
        if (term == 0 || (term == 2 && k == 0)) begin
            msg_end = 1'b1;
            cycle();
            msg_end = 1'b0;
        end
        for (int c = 0; c < 3 * TO && busy; c++) cycle();
        check({tag, ".finished"}, busy, 0);
        cycle();
        wn = (k < n) ? k : n;
        if (k > n)       exp_err = 2'b11;
        else if (k == n) exp_err = 2'b00;
        else if (term == 1) exp_err = 2'b01;
        else             exp_err = 2'b10;
        check({tag, ".done_pulses"}, n_done - d0, (k == n) ? 1 : 0);
        check({tag, ".err_pulses"},  n_err - e0,  (k == n) ? 0 : 1);
        check({tag, ".err_code"}, err_code, exp_err);
        check({tag, ".word_cnt"}, word_cnt, wn);
        check({tag, ".nwrites"}, wa_q.size(), wn);
        for (int i = 0; i < wn && i < wa_q.size(); i++) begin
            check({tag, ".waddr"}, wa_q[i], i);
            check({tag, ".wdata"}, wd_q[i], wq[i]);
        end
    endtask

    task automatic fill_random(input int k);
        wq.delete();
        for (int i = 0; i < k; i++) wq.push_back(DW'($urandom));
    endtask

    initial begin
        int n, k, term, d0, e0;
        reset = 1'b1;
        cmd_valid = 0; cmd_word = '0; data_valid = 0; data_word = '0; msg_end = 0;
        host_rd_req = 0; host_rd_addr = '0;
        cycle(); cycle();
        check("rst.busy", busy, 0);
        check("rst.done", msg_done, 0);
        check("rst.error", msg_error, 0);
        check("rst.err_code", err_code, 0);
        check("rst.word_cnt", word_cnt, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.rd_valid", host_rd_valid, 0);
        reset = 1'b0;
        cycle();

        // Basic three-word message, then host reads of its contents.
        wq.delete();
        wq.push_back(16'hA001); wq.push_back(16'hA002); wq.push_back(16'hA003);
        run_msg("basic3", 3, 0, 0);
        host_rd_req  = 1'b1;
        host_rd_addr = 5'd1;
        cycle();
        host_rd_req = 1'b0;
        check("hrd.valid", host_rd_valid, 1);
        check("hrd.data", host_rd_data, 16'hA002);
        cycle();
        check("hrd.valid_drop", host_rd_valid, 0);

        fill_random(32); run_msg("full32", 32, 0, 0);
        fill_random(2);  run_msg("timeout", 4, 1, 0);
        fill_random(3);  run_msg("overrun", 2, 0, 0);
        fill_random(1);  run_msg("short", 5, 0, 0);
        fill_random(3);  run_msg("rd_busy", 3, 0, 1);
        fill_random(4);  run_msg("coincide", 4, 2, 0);
        fill_random(0);  run_msg("empty", 1, 0, 0);

        // Reset mid-message, then a fresh message must restart at address 0.
        d0 = n_done;
        e0 = n_err;
        send_cmd(4);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        #2 reset = 1'b1;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.word_cnt", word_cnt, 0);
        check("midrst.mem_we", mem_we, 0);
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        check("midrst.no_done", n_done - d0, 0);
        check("midrst.no_error", n_err - e0, 0);
        fill_random(2); run_msg("after_rst", 2, 0, 0);

        for (int r = 0; r < 12; r++) begin
            n    = $urandom_range(1, 32);
            k    = n - 1 + int'($urandom_range(0, 2));
            term = $urandom_range(0, 2);
            fill_random(k);
            run_msg("rand", n, term, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
